// File: rtl/mips_fetch_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_fetch_queue_if: instruction-memory and decode-side bundle   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mips_fetch_queue_if #(
  parameter int AW = 10
) ();
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic [31:0]   out_ir;
  logic [31:0]   out_npc;
  logic          out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_ir, out_npc,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_ir, out_npc,
    output imem_rdata, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/mips_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_fetch_queue: PC owner + prefetch FIFO feeding IF/ID         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mips_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  wire logic                         clk1,
  input  wire logic                         rst_n,
  input  wire logic                         halted,
  input  wire logic                         redirect_valid,
  input  wire logic [31:0]                  redirect_pc,
  mips_fetch_queue_if.master                bus,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int               c_CW       = $clog2(DEPTH + 1);
  localparam int               c_PW       = $clog2(DEPTH);
  localparam logic [c_CW:0]    c_DEPTH    = (c_CW + 1)'(DEPTH);
  localparam logic [c_PW-1:0]  c_PTR_ONE  = c_PW'(1);
  localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);

  logic [31:0]     r_pc;
  logic [31:0]     r_pend_npc;
  logic            r_pend_valid;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;
  logic [31:0]     r_ir_q  [DEPTH];
  logic [31:0]     r_npc_q [DEPTH];

  logic            w_redirect;
  logic            w_issue;
  logic            w_pop;
  logic [c_CW:0]   w_occ;

  // The in-flight word already owns a slot, so it counts toward occupancy.
  assign w_occ      = {1'b0, r_count} + {{c_CW{1'b0}}, r_pend_valid};
  assign w_redirect = redirect_valid && !halted;
  assign w_issue    = !halted && !redirect_valid && (w_occ < c_DEPTH);
  assign w_pop      = bus.out_valid && bus.out_ready;

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_pc[AW-1:0];
  assign bus.out_valid = (r_count != '0) && !halted;
  assign bus.out_ir    = r_ir_q[r_rd_ptr];
  assign bus.out_npc   = r_npc_q[r_rd_ptr];
  assign count         = r_count;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_pc         <= '0;
      r_pend_npc   <= '0;
      r_pend_valid <= 1'b0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ir_q[i]  <= '0;
        r_npc_q[i] <= '0;
      end
    end else if (w_redirect) begin
      r_pc         <= redirect_pc;
      r_pend_valid <= 1'b0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      if (w_issue) begin
        r_pc       <= r_pc + 32'd1;
        r_pend_npc <= r_pc + 32'd1;
      end
      r_pend_valid <= w_issue;

      // Capture is not gated by halted so a returning word is never dropped.
      if (r_pend_valid) begin
        r_ir_q[r_wr_ptr]  <= bus.imem_rdata;
        r_npc_q[r_wr_ptr] <= r_pend_npc;
        r_wr_ptr          <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      case ({r_pend_valid, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mips_fetch_queue: random + directed bench with queue model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mips_fetch_queue;

  localparam int c_DEPTH = 4;
  localparam int c_AW    = 10;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [2:0]  count;

  mips_fetch_queue_if #(.AW(c_AW)) bus ();

  mips_fetch_queue #(.DEPTH(c_DEPTH), .AW(c_AW)) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .halted         (halted),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .count          (count)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] mem [1024];

  always @(posedge clk1) begin
    if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
  end

  // Reference model: list of queued words, fetch PC and one in-flight slot.
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_ir;
  logic [31:0] m_pend_npc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = '0;
    m_pend = 1'b0;
  endtask

  // Drive one cycle of inputs, compare outputs to the model, advance the model.
  task automatic step(input logic h, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic req, vld;
    ent_t e;
    @(negedge clk1);
    rst_n          = 1'b1;
    halted         = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    bus.out_ready  = rdy;
    #2;
    req = !h && !rv && ((m_q.size() + int'(m_pend)) < c_DEPTH);
    vld = (m_q.size() != 0) && !h;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, req});
    if (req) chk("imem_addr", {22'b0, bus.imem_addr}, {22'b0, m_pc[c_AW-1:0]});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, vld});
    chk("count", {29'b0, count}, 32'(m_q.size()));
    if (vld) begin
      chk("out_ir", bus.out_ir, m_q[0].ir);
      chk("out_npc", bus.out_npc, m_q[0].npc);
    end
    if (rv && !h) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = rpc;
    end else begin
      if (vld && rdy) void'(m_q.pop_front());
      if (m_pend) begin
        e.ir  = m_pend_ir;
        e.npc = m_pend_npc;
        m_q.push_back(e);
      end
      m_pend = req;
      if (req) begin
        m_pend_ir  = mem[m_pc[c_AW-1:0]];
        m_pend_npc = m_pc + 32'd1;
        m_pc       = m_pc + 32'd1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n          = 1'b0;
    halted         = 1'b0;
    redirect_valid = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (2) @(negedge clk1);
    #2;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_ir", bus.out_ir, 32'd0);
    chk("rst_out_npc", bus.out_npc, 32'd0);
    model_reset();
  endtask

  logic [31:0] rpc;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
    bus.out_ready = 1'b0;
    model_reset();

    // Streaming from reset
    do_reset();
    step(0, 0, 0, 1);
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    chk("first_addr", {22'b0, bus.imem_addr}, 32'd0);
    step(0, 0, 0, 1);
    chk("lat_no_valid", {31'b0, bus.out_valid}, 32'd0);
    step(0, 0, 0, 1);
    chk("stream0_ir", bus.out_ir, 32'h1000_0000);
    chk("stream0_npc", bus.out_npc, 32'd1);
    step(0, 0, 0, 1);
    chk("stream1_ir", bus.out_ir, 32'h1000_0001);
    chk("stream1_npc", bus.out_npc, 32'd2);

    // Backpressure fills the queue
    repeat (10) step(0, 0, 0, 0);
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_no_req", {31'b0, bus.imem_req}, 32'd0);
    repeat (12) step(0, 0, 0, 1);

    // Redirect with 3 queued and one in flight
    do_reset();
    repeat (4) step(0, 0, 0, 0);
    step(0, 1, 32'h20, 0);
    chk("pre_redir_count", {29'b0, count}, 32'd3);
    step(0, 0, 0, 1);
    chk("post_redir_count", {29'b0, count}, 32'd0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("redir_ir", bus.out_ir, 32'h1000_0020);
    chk("redir_npc", bus.out_npc, 32'h21);
    repeat (3) step(0, 0, 0, 1);

    // Redirect colliding with a pop and a capture
    step(0, 1, 32'h100, 1);
    step(0, 0, 0, 1);
    chk("collide_empty", {31'b0, bus.out_valid}, 32'd0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("collide_ir", bus.out_ir, 32'h1000_0100);
    chk("collide_npc", bus.out_npc, 32'h101);

    // Address wrap at 2^AW
    step(0, 1, 32'h3FF, 1);
    step(0, 0, 0, 1);
    chk("wrap_addr0", {22'b0, bus.imem_addr}, 32'h3FF);
    step(0, 0, 0, 1);
    chk("wrap_addr1", {22'b0, bus.imem_addr}, 32'h0);
    step(0, 0, 0, 1);
    chk("wrap_npc0", bus.out_npc, 32'h400);
    chk("wrap_ir0", bus.out_ir, 32'h1000_03FF);
    step(0, 0, 0, 1);
    chk("wrap_npc1", bus.out_npc, 32'h401);
    chk("wrap_ir1", bus.out_ir, 32'h1000_0000);

    // Halt with a word in flight; redirect ignored while halted
    do_reset();
    repeat (4) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("halt_count", {29'b0, count}, 32'd1);
    chk("halt_no_valid", {31'b0, bus.out_valid}, 32'd0);
    step(1, 1, 32'h50, 1);
    chk("halt_capture", {29'b0, count}, 32'd2);
    chk("halt_no_req", {31'b0, bus.imem_req}, 32'd0);
    step(1, 0, 0, 1);
    chk("halt_redir_ignored", {29'b0, count}, 32'd2);
    repeat (6) step(0, 0, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      case ($urandom_range(0, 3))
        0:       rpc = 32'h3F0 + $urandom_range(0, 15);
        1:       rpc = 32'hFFFF_FFFC + $urandom_range(0, 3);
        default: rpc = $urandom_range(0, 1023);
      endcase
      step($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, rpc,
           $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
